// File: rtl/ifetch_resp.sv
// rtl/ifetch_resp.sv - instruction-fetch responder between the PC register and instruction memory
module ifetch_resp #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int              TIMEOUT   = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    input  logic            req,
    input  logic            flush,
    input  logic            decode_stall,
    output logic            stall,
    output logic            mem_rd,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    output logic            instr_fault
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            mem_rd_n;
    logic [XLEN-1:0] mem_addr_n;
    logic [XLEN-1:0] instr_n;
    logic [XLEN-1:0] instr_pc_n;
    logic            valid_n;
    logic            fault_n;
    logic            kill;
    logic            kill_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic            aligned;
    logic            timed_out;
    logic            do_issue;
    logic            do_fault;

    assign aligned   = (pc[1:0] == 2'b00);
    assign timed_out = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_n    = state;
        mem_rd_n   = mem_rd;
        mem_addr_n = mem_addr;
        instr_n    = instr;
        instr_pc_n = instr_pc;
        valid_n    = instr_valid;
        fault_n    = instr_fault;
        kill_n     = kill;
        cnt_n      = cnt;
        stall      = 1'b0;
        do_issue   = 1'b0;
        do_fault   = 1'b0;

        case (state)
            S_IDLE: begin
                stall = req && !flush;
                if (req && !flush) begin
                    do_issue = aligned;
                    do_fault = !aligned;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                cnt_n = cnt + CW'(1);
                if (flush) begin
                    kill_n = 1'b1;
                end
                // An ack in the timeout cycle still counts as a normal completion.
                if (mem_ack || timed_out) begin
                    mem_rd_n = 1'b0;
                    kill_n   = 1'b0;
                    if (kill || flush) begin
                        state_n = S_IDLE;
                    end else if (mem_ack) begin
                        state_n = S_VALID;
                        instr_n = mem_rdata;
                        fault_n = 1'b0;
                        valid_n = 1'b1;
                    end else begin
                        state_n = S_VALID;
                        instr_n = NOP_INSTR;
                        fault_n = 1'b1;
                        valid_n = 1'b1;
                    end
                end
            end
            S_VALID: begin
                stall = decode_stall;
                if (flush) begin
                    valid_n = 1'b0;
                    state_n = S_IDLE;
                end else if (!decode_stall) begin
                    if (req) begin
                        do_issue = aligned;
                        do_fault = !aligned;
                    end else begin
                        valid_n = 1'b0;
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (do_issue) begin
            state_n    = S_WAIT;
            mem_rd_n   = 1'b1;
            mem_addr_n = {pc[XLEN-1:2], 2'b00};
            instr_pc_n = pc;
            cnt_n      = '0;
            valid_n    = 1'b0;
        end
        // Misaligned pc never touches memory; decode receives a faulting NOP.
        if (do_fault) begin
            state_n    = S_VALID;
            instr_n    = NOP_INSTR;
            instr_pc_n = pc;
            fault_n    = 1'b1;
            valid_n    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            instr_fault <= 1'b0;
            kill        <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            mem_rd      <= mem_rd_n;
            mem_addr    <= mem_addr_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            instr_valid <= valid_n;
            instr_fault <= fault_n;
            kill        <= kill_n;
            cnt         <= cnt_n;
        end
    end

endmodule

// File: tb/tb_ifetch_resp.sv
// tb/tb_ifetch_resp.sv - self-checking bench for ifetch_resp
module tb_ifetch_resp;

    localparam int          TMO = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic        req = 1'b0;
    logic        flush = 1'b0;
    logic        decode_stall = 1'b0;
    logic        stall;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_fault;

    int          errors = 0;
    int          checks = 0;
    logic        auto_pc = 1'b0;
    int          ack_lat = 1;
    int          ack_cnt = 0;
    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic [31:0] resp_data = '0;
    int          vcyc[$];
    logic [31:0] vpc[$];
    int          n;

    ifetch_resp #(.XLEN(32), .NOP_INSTR(NOP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .req(req), .flush(flush),
        .decode_stall(decode_stall), .stall(stall), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_fault(instr_fault)
    );

    always #5 clk = ~clk;

    assign mem_ack   = resp_ack | stray_ack;
    assign mem_rdata = resp_data;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'hFFFF_FFFC) return 32'h0000_0093;
        return {8'hA5, a[23:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Memory: ack arrives in the ack_lat-th cycle that mem_rd is seen high (0 = never).
    initial forever begin
        @(negedge clk);
        if (!rst_n || !mem_rd) begin
            ack_cnt  = 0;
            resp_ack = 1'b0;
        end else begin
            ack_cnt++;
            resp_ack  = (ack_lat != 0) && (ack_cnt == ack_lat);
            resp_data = resp_ack ? word_at(mem_addr) : 32'hDEAD_BEEF;
        end
    end

    // Reference model: one outstanding fetch, at most one held instruction.
    logic        m_inflight = 1'b0;
    logic        m_killed = 1'b0;
    logic        m_held = 1'b0;
    int          m_waited = 0;
    logic        e_rd = 1'b0;
    logic        e_valid = 1'b0;
    logic        e_fault = 1'b0;
    logic [31:0] e_addr = '0;
    logic [31:0] e_instr = '0;
    logic [31:0] e_ipc = '0;

    task automatic deliver(input logic [31:0] w, input logic f);
        e_instr = w;
        e_fault = f;
        e_valid = 1'b1;
        m_held  = 1'b1;
    endtask

    task automatic model_step();
        logic free;
        if (m_inflight) begin
            m_waited++;
            if (flush) m_killed = 1'b1;
            if (mem_ack || m_waited >= TMO) begin
                m_inflight = 1'b0;
                e_rd = 1'b0;
                if (!m_killed) deliver(mem_ack ? mem_rdata : NOP, !mem_ack);
                m_killed = 1'b0;
            end
        end else begin
            free = !m_held || (!flush && !decode_stall);
            if (m_held && (flush || !decode_stall)) begin
                m_held  = 1'b0;
                e_valid = 1'b0;
            end
            if (free && req && !flush) begin
                e_ipc = pc;
                if (pc[1:0] == 2'b00) begin
                    m_inflight = 1'b1;
                    m_waited = 0;
                    e_rd = 1'b1;
                    e_addr = pc;
                end else begin
                    deliver(NOP, 1'b1);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_inflight = 1'b0; m_killed = 1'b0; m_held = 1'b0; m_waited = 0;
            e_rd = 1'b0; e_valid = 1'b0; e_fault = 1'b0;
            e_addr = '0; e_instr = '0; e_ipc = '0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison against the model, after inputs settle.
    initial forever begin
        @(negedge clk);
        #1;
        chk("cmp_mem_rd", {31'b0, mem_rd}, {31'b0, e_rd});
        chk("cmp_valid", {31'b0, instr_valid}, {31'b0, e_valid});
        chk("cmp_stall", {31'b0, stall},
            {31'b0, m_inflight || (m_held && decode_stall) ||
                    (!m_inflight && !m_held && req && !flush)});
        if (e_rd) chk("cmp_mem_addr", mem_addr, e_addr);
        if (e_valid) begin
            chk("cmp_instr", instr, e_instr);
            chk("cmp_instr_pc", instr_pc, e_ipc);
            chk("cmp_fault", {31'b0, instr_fault}, {31'b0, e_fault});
        end
    end

    task automatic tick(input logic r, input logic f, input logic ds);
        @(negedge clk);
        if (auto_pc && !stall) pc = pc + 32'd4;
        req = r;
        flush = f;
        decode_stall = ds;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #2;
        chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_fault", {31'b0, instr_fault}, 32'd0);
        tick(0, 0, 0); rst_n = 1'b1;
        tick(0, 0, 0);

        // Single fetch at the top of the address space.
        ack_lat = 1;
        tick(1, 0, 0); pc = 32'hFFFF_FFFC;
        tick(1, 0, 0); #2;
        chk("t1_mem_rd", {31'b0, mem_rd}, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'hFFFF_FFFC);
        chk("t1_stall", {31'b0, stall}, 32'd1);
        tick(0, 0, 0); #2;
        chk("t1_valid", {31'b0, instr_valid}, 32'd1);
        chk("t1_instr", instr, 32'h0000_0093);
        chk("t1_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("t1_fault", {31'b0, instr_fault}, 32'd0);
        tick(0, 0, 0);

        // Back-to-back stream with the PC stage advancing on !stall.
        tick(1, 0, 0); pc = 32'h0; auto_pc = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(i < 6, 0, 0); #2;
            if (instr_valid) begin
                vcyc.push_back(i);
                vpc.push_back(instr_pc);
            end
            if (i == 4) chk("t2_instr4", instr, 32'hA500_0004);
        end
        auto_pc = 1'b0;
        chk("t2_count", vcyc.size(), 32'd3);
        for (int k = 0; k < vcyc.size() && k < 3; k++) begin
            chk("t2_instr_pc", vpc[k], 32'(4 * k));
            chk("t2_cycle", vcyc[k], 32'(2 * (k + 1)));
        end

        // Decode backpressure while holding an instruction.
        tick(1, 0, 0); pc = 32'h40;
        tick(1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 1); #2;
            chk("t3_hold_pc", instr_pc, 32'h40);
            chk("t3_hold_instr", instr, 32'hA500_0040);
            chk("t3_hold_stall", {31'b0, stall}, 32'd1);
            chk("t3_hold_rd", {31'b0, mem_rd}, 32'd0);
        end
        tick(1, 0, 0); pc = 32'h44;
        tick(1, 0, 0); #2;
        chk("t3_reissue_rd", {31'b0, mem_rd}, 32'd1);
        chk("t3_reissue_addr", mem_addr, 32'h44);
        tick(0, 0, 0); #2;
        chk("t3_next_pc", instr_pc, 32'h44);
        tick(0, 0, 0);

        // Flush two cycles into a slow fetch.
        ack_lat = 5;
        tick(1, 0, 0); pc = 32'h20;
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(1, 1, 0); pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0); #2;
            chk("t4_killed_valid", {31'b0, instr_valid}, 32'd0);
        end
        ack_lat = 1;
        tick(1, 0, 0); #2;
        chk("t4_redirect_rd", {31'b0, mem_rd}, 32'd1);
        chk("t4_redirect_addr", mem_addr, 32'h100);
        tick(0, 0, 0); #2;
        chk("t4_redirect_pc", instr_pc, 32'h100);
        chk("t4_redirect_instr", instr, 32'hA500_0100);
        tick(0, 0, 0);

        // Misaligned pc, then a misaligned reload straight from VALID.
        tick(1, 0, 0); pc = 32'h102;
        tick(1, 0, 0); pc = 32'h106; #2;
        chk("t5_no_rd", {31'b0, mem_rd}, 32'd0);
        chk("t5_valid", {31'b0, instr_valid}, 32'd1);
        chk("t5_fault", {31'b0, instr_fault}, 32'd1);
        chk("t5_instr", instr, NOP);
        chk("t5_instr_pc", instr_pc, 32'h102);
        tick(0, 0, 0); #2;
        chk("t5_reload_pc", instr_pc, 32'h106);
        chk("t5_reload_fault", {31'b0, instr_fault}, 32'd1);
        tick(0, 0, 0); #2;
        chk("t5_idle_valid", {31'b0, instr_valid}, 32'd0);

        // Timeout with no ack; req drops during WAIT without aborting.
        ack_lat = 0;
        tick(1, 0, 0); pc = 32'h200;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick(0, 0, 0); #2;
            if (!mem_rd) break;
            n++;
        end
        chk("t6_wait_cycles", n, 32'd64);
        chk("t6_valid", {31'b0, instr_valid}, 32'd1);
        chk("t6_fault", {31'b0, instr_fault}, 32'd1);
        chk("t6_instr", instr, NOP);
        chk("t6_instr_pc", instr_pc, 32'h200);
        tick(0, 0, 0);

        // Ack in the timeout cycle wins as a normal completion.
        ack_lat = 64;
        tick(1, 0, 0); pc = 32'h240;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick(0, 0, 0); #2;
            if (!mem_rd) break;
            n++;
        end
        chk("t6b_wait_cycles", n, 32'd64);
        chk("t6b_fault", {31'b0, instr_fault}, 32'd0);
        chk("t6b_instr", instr, 32'hA500_0240);
        tick(0, 0, 0);

        // Asynchronous reset mid-WAIT, then a stray ack in IDLE.
        ack_lat = 3;
        tick(1, 0, 0); pc = 32'h300;
        tick(1, 0, 0); #3;
        rst_n = 1'b0; #1;
        chk("t7_rst_rd", {31'b0, mem_rd}, 32'd0);
        chk("t7_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("t7_rst_addr", mem_addr, 32'd0);
        tick(0, 0, 0);
        tick(0, 0, 0); rst_n = 1'b1; stray_ack = 1'b1;
        tick(0, 0, 0); stray_ack = 1'b0; #2;
        chk("t7_stray_rd", {31'b0, mem_rd}, 32'd0);
        chk("t7_stray_valid", {31'b0, instr_valid}, 32'd0);
        ack_lat = 1;
        tick(1, 0, 0); pc = 32'h400;
        tick(1, 0, 0);
        tick(0, 0, 0); #2;
        chk("t7_after_valid", {31'b0, instr_valid}, 32'd1);
        chk("t7_after_pc", instr_pc, 32'h400);
        tick(0, 0, 0);
        tick(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
